// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Step counter must be able to hold values up to the operand width.
  function automatic int unsigned count_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cla_nbit.sv
// Parametrised carry-lookahead adder, generalised from the original 8-bit CLA.
module cla_nbit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             term;
  logic             cy;

  assign g = A & B;
  assign p = A ^ B;

  // Each carry is a flat sum of generate/propagate products, not a ripple chain.
  always_comb begin
    c    = '0;
    term = 1'b0;
    cy   = 1'b0;
    c[0] = Cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      term = Cin;
      for (int unsigned k = 0; k <= i; k++) begin
        term = term & p[k];
      end
      cy = term;
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        cy = cy | term;
      end
      c[i+1] = cy;
    end
  end

  assign Sum  = p ^ c[WIDTH-1:0];
  assign Cout = c[WIDTH];

endmodule

// File: rtl/multiplier_seq.sv
// Iterative shift-add multiplier, one CLA add per cycle over WIDTH cycles,
// valid/ready on both sides. Define MULTIPLIER_SIGNED_EN to honour
// signed_mode (two's-complement operands and product); otherwise unsigned only.
module multiplier_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
);

  localparam int unsigned   CW   = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic               rdy_q;
  logic               vld_q;
  logic               rdy_next;
  logic               vld_next;
  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_load;
  logic [CW-1:0]      count;
  logic               unused_acc_lsb;

`ifdef MULTIPLIER_SIGNED_EN
  logic neg;
  logic neg_in;

  // Magnitudes stay unsigned WIDTH-bit, so -2^(W-1) maps to 2^(W-1) exactly.
  assign mag_a     = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (signed_mode && b[WIDTH-1]) ? -b : b;
  assign neg_in    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign prod_load = neg ? -acc_step : acc_step;

  // Result sign captured alongside the operands.
  always_ff @(posedge clk) begin
    if (rst)         neg <= 1'b0;
    else if (accept) neg <= neg_in;
  end
`else
  logic unused_signed_mode;

  assign unused_signed_mode = signed_mode;
  assign mag_a              = a;
  assign mag_b              = b;
  assign prod_load          = acc_step;
`endif

  assign accept    = (state == IDLE) && rdy_q && in_valid;
  assign last_step = (state == BUSY) && (count == LAST);
  assign add_b     = mplier[0] ? mcand : '0;

  cla_nbit #(.WIDTH(WIDTH)) u_cla (
    .A    (acc[2*WIDTH-1:WIDTH]),
    .B    (add_b),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  // Carry-out becomes the new MSB as the accumulator shifts right.
  assign acc_step       = {cout, sum, acc[WIDTH-1:1]};
  assign unused_acc_lsb = acc[0];

  // Next-state decode; handshake flags are pre-decoded for registering.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    rdy_next = (state_next == IDLE);
    vld_next = (state_next == DONE);
  end

  // State and handshake flag registers; in_ready held low through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      state <= state_next;
      rdy_q <= rdy_next;
      vld_q <= vld_next;
    end
  end

  // Operand capture, shift-add iteration and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      prod_q <= '0;
    end else if (accept) begin
      mcand  <= mag_a;
      mplier <= mag_b;
      acc    <= '0;
      count  <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_step;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (last_step) prod_q <= prod_load;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign prod      = prod_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq at WIDTH=8 and WIDTH=13 with a
// result scoreboard; expectations follow MULTIPLIER_SIGNED_EN.
module tb_multiplier_seq;

  localparam bit SIGNED_EN =
`ifdef MULTIPLIER_SIGNED_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        iv8, ir8, sm8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv13, ir13, sm13, ov13, or13;
  logic [12:0] a13, b13;
  logic [25:0] p13;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q8[$];
  logic [25:0] q13[$];

  always #5 clk = ~clk;

  multiplier_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .prod(p8)
  );

  multiplier_seq #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .in_valid(iv13), .in_ready(ir13), .a(a13), .b(b13),
    .signed_mode(sm13), .out_valid(ov13), .out_ready(or13), .prod(p13)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product, masked to 2*w bits.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                          input logic sm, input int unsigned w);
    longint sx, sy, pr;
    sx = longint'(x);
    sy = longint'(y);
    if (SIGNED_EN && sm) begin
      if (x[w-1]) sx = sx - (longint'(1) << w);
      if (y[w-1]) sy = sy - (longint'(1) << w);
    end
    pr = sx * sy;
    return 32'(pr) & ((32'd1 << (2 * w)) - 32'd1);
  endfunction

  // Offer one operand pair, wait for acceptance, push expected result.
  task automatic send(input bit wide, input logic [12:0] x, input logic [12:0] y, input logic sm);
    bit          took;
    int          n;
    logic [31:0] e;
    took = 1'b0;
    n    = 0;
    if (wide) begin a13 = x; b13 = y; sm13 = sm; iv13 = 1'b1; end
    else      begin a8 = x[7:0]; b8 = y[7:0]; sm8 = sm; iv8 = 1'b1; end
    while (!took && n < 64) begin
      took = wide ? (ir13 === 1'b1) : (ir8 === 1'b1);
      tick();
      n++;
    end
    if (wide) iv13 = 1'b0; else iv8 = 1'b0;
    checks++;
    if (!took) begin
      failures++;
      $display("FAIL accept_timeout wide=%0d: in_ready not seen within %0d cycles", wide, n);
    end else if (wide) begin
      e = ref_mul({3'b0, x}, {3'b0, y}, sm, 13);
      q13.push_back(e[25:0]);
    end else begin
      e = ref_mul({8'b0, x[7:0]}, {8'b0, y[7:0]}, sm, 8);
      q8.push_back(e[15:0]);
    end
  endtask

  // Edges counted from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_out8(output int n);
    n = 1;
    while (ov8 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic handoff8();
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (ir8 !== 1'b0 || ir13 !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready: got %b/%b, expected 0/0", ir8, ir13);
    end
    checks++;
    if (ov8 !== 1'b0 || ov13 !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b/%b, expected 0/0", ov8, ov13);
    end
    checks++;
    if (p8 !== 16'h0 || p13 !== 26'h0) begin
      failures++;
      $display("FAIL reset_prod: got %h/%h, expected 0/0", p8, p13);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || ir13 !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: in_ready8=%b out_valid8=%b in_ready13=%b, expected 1 0 1",
               ir8, ov8, ir13);
    end
  endtask

  task automatic test_unsigned();
    int          n;
    logic [15:0] e;
    send(1'b0, 13'h0FF, 13'h0FF, 1'b0);
    wait_out8(n);
    checks++;
    if (n != 9) begin
      failures++;
      $display("FAIL unsigned_latency: out_valid at edge %0d, expected 9", n);
    end
    e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
    checks++;
    if (p8 !== e || p8 !== 16'hFE01) begin
      failures++;
      $display("FAIL unsigned_ffxff: got %h, expected %h", p8, e);
    end
    handoff8();
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      failures++;
      $display("FAIL unsigned_handoff: out_valid=%b in_ready=%b, expected 0 1", ov8, ir8);
    end
  endtask

  task automatic test_signed();
    logic [7:0]  va[4] = '{8'h80, 8'hFF, 8'h85, 8'hFF};
    logic [7:0]  vb[4] = '{8'h80, 8'h01, 8'h07, 8'h01};
    logic        vs[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    int          n;
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, {5'b0, va[i]}, {5'b0, vb[i]}, vs[i]);
      wait_out8(n);
      e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
      checks++;
      if (n != 9 || p8 !== e) begin
        failures++;
        $display("FAIL signed_mode %h*%h: got %h at edge %0d, expected %h at edge 9",
                 va[i], vb[i], p8, n, e);
      end
      handoff8();
    end
  endtask

  task automatic test_backpressure();
    int          n;
    logic [15:0] e, held;
    send(1'b0, 13'h0A7, 13'h03C, 1'b0);
    wait_out8(n);
    held = p8;
    e    = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
    checks++;
    if (p8 !== e) begin
      failures++;
      $display("FAIL backpressure_value: got %h, expected %h", p8, e);
    end
    // Offers made while DONE must be ignored.
    a8 = 8'h55; b8 = 8'h66; sm8 = 1'b0; iv8 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (p8 !== held || ir8 !== 1'b0 || ov8 !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_hold cycle %0d: prod=%h in_ready=%b out_valid=%b, expected %h 0 1",
                 i, p8, ir8, ov8, held);
      end
    end
    iv8 = 1'b0;
    handoff8();
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, expected 0 1", ov8, ir8);
    end
  endtask

  task automatic test_reset_midop();
    int          n;
    logic [15:0] e;
    send(1'b0, 13'h033, 13'h044, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (q8.size() > 0) void'(q8.pop_back());
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (ov8 !== 1'b0) begin
        failures++;
        $display("FAIL reset_midop_discard cycle %0d: out_valid=%b, expected 0", i, ov8);
      end
      tick();
    end
    send(1'b0, 13'h00C, 13'h00D, 1'b0);
    wait_out8(n);
    e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
    checks++;
    if (n != 9 || p8 !== e || p8 !== 16'h009C) begin
      failures++;
      $display("FAIL reset_midop_next: got %h at edge %0d, expected %h at edge 9", p8, n, e);
    end
    handoff8();
  endtask

  // Random operands, modes, offer gaps and consumer stalls on one instance.
  task automatic test_random(input bit wide, input int nops);
    fork
      begin
        for (int i = 0; i < nops; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          send(wide, 13'($urandom), 13'($urandom), 1'($urandom_range(0, 1)));
        end
      end
      begin
        int          got = 0;
        int          cyc = 0;
        bit          hs;
        logic [31:0] val, e;
        while (got < nops && cyc < nops * 60) begin
          if (wide) or13 = 1'($urandom_range(0, 1)); else or8 = 1'($urandom_range(0, 1));
          hs  = wide ? (ov13 === 1'b1 && or13) : (ov8 === 1'b1 && or8);
          val = wide ? 32'(p13) : 32'(p8);
          tick();
          cyc++;
          if (hs) begin
            got++;
            checks++;
            if ((wide ? q13.size() : q8.size()) == 0) begin
              failures++;
              $display("FAIL random_extra wide=%0d: result %h with nothing outstanding", wide, val);
            end else begin
              e = wide ? 32'(q13.pop_front()) : 32'(q8.pop_front());
              if (val !== e) begin
                failures++;
                $display("FAIL random_prod wide=%0d #%0d: got %h, expected %h", wide, got, val, e);
              end
            end
          end
        end
        or8  = 1'b0;
        or13 = 1'b0;
        checks++;
        if (got != nops) begin
          failures++;
          $display("FAIL random_count wide=%0d: got %0d results, expected %0d", wide, got, nops);
        end
      end
    join
    checks++;
    if ((wide ? q13.size() : q8.size()) != 0) begin
      failures++;
      $display("FAIL random_leftover wide=%0d: %0d results never delivered", wide,
               wide ? q13.size() : q8.size());
    end
  endtask

  initial begin
    rst  = 1'b1;
    iv8  = 1'b0; or8  = 1'b0; a8  = '0; b8  = '0; sm8  = 1'b0;
    iv13 = 1'b0; or13 = 1'b0; a13 = '0; b13 = '0; sm13 = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_midop();
    test_random(1'b0, 60);
    test_random(1'b1, 40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
